// File: rtl/riscv_trace_pkg.sv
// Shared types for the commit tracer: the buffered commit entry and default sizing.
package riscv_trace_pkg;

  localparam int TRACE_DEPTH_DEFAULT = 4;
  localparam int TRACE_XLEN          = 32;
  localparam logic [4:0] REG_X0      = 5'd0;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [31:0]           instr;
    logic [TRACE_XLEN-1:0] result;
    logic [4:0]            rd;
    logic                  regwrite;
  } commit_entry_t;

endpackage

// File: rtl/riscv_trace_fifo.sv
// Synchronous FIFO of commit entries with registered occupancy and full/empty flags.
module riscv_trace_fifo
  import riscv_trace_pkg::*;
#(
  parameter int DEPTH = TRACE_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  commit_entry_t          i_din,
  output commit_entry_t          o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  commit_entry_t   r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  // Guards make overflow/underflow impossible even if the caller misbehaves.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; emptiness is tracked solely by the count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/riscv_commit_tracer.sv
// Commit trace producer: buffers WB retirements and hands them to the monitor one per handshake.
// Optional COMMIT_TRACE_INSTRET_EN adds a 64-bit sequence number for the displayed entry.
module riscv_commit_tracer
  import riscv_trace_pkg::*;
#(
  parameter int DEPTH = TRACE_DEPTH_DEFAULT,
  parameter int XLEN  = TRACE_XLEN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   trace_en,
  input  logic                   wb_valid,
  output logic                   wb_ready,
  input  logic [XLEN-1:0]        wb_pc,
  input  logic [31:0]            wb_instr,
  input  logic [XLEN-1:0]        wb_result,
  input  logic [4:0]             wb_rd,
  input  logic                   wb_regwrite,
  output logic                   monitor_valid,
  input  logic                   monitor_ready,
  output logic [XLEN-1:0]        monitor_pc,
  output logic [31:0]            monitor_instr,
  output logic [XLEN-1:0]        monitor_result,
  output logic [4:0]             monitor_rd,
  output logic                   monitor_regwrite,
`ifdef COMMIT_TRACE_INSTRET_EN
  output logic [63:0]            monitor_instret,
`endif
  output logic [$clog2(DEPTH):0] fifo_level
);

  commit_entry_t w_wr_entry;
  commit_entry_t w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  // Ready depends only on registered state, never on monitor_ready.
  assign wb_ready      = trace_en ? !w_full : 1'b1;
  assign w_push        = wb_valid && trace_en && !w_full;
  assign monitor_valid = !w_empty;
  assign w_pop         = monitor_valid && monitor_ready;

  always_comb begin
    w_wr_entry          = '0;
    w_wr_entry.pc       = wb_pc;
    w_wr_entry.instr    = wb_instr;
    w_wr_entry.result   = wb_result;
    w_wr_entry.rd       = wb_rd;
    w_wr_entry.regwrite = wb_regwrite && (wb_rd != REG_X0);
  end

  riscv_trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_wr_entry),
    .o_head  (w_head),
    .o_count (fifo_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Empty FIFO presents all-zero data rather than stale storage.
  assign monitor_pc       = w_empty ? '0   : w_head.pc;
  assign monitor_instr    = w_empty ? '0   : w_head.instr;
  assign monitor_result   = w_empty ? '0   : w_head.result;
  assign monitor_rd       = w_empty ? '0   : w_head.rd;
  assign monitor_regwrite = w_empty ? 1'b0 : w_head.regwrite;

`ifdef COMMIT_TRACE_INSTRET_EN
  logic [63:0] r_instret;

  always_ff @(posedge clk) begin
    if (reset)      r_instret <= '0;
    else if (w_pop) r_instret <= r_instret + 64'd1;
  end

  assign monitor_instret = r_instret;
`endif

endmodule

// File: doc/riscv_commit_tracer.md
Name: riscv_commit_tracer

Overview:
- Processor-side producer of the commit trace consumed by the verification monitor.
- Captures each retired instruction from the writeback stage and buffers it in a small FIFO.
- Presents retired instructions one per handshake on the monitor_* signals. Normalises x0 writes on the way.
- Sits between the core's WB stage and the top-level monitor port; applies back-pressure to WB when the buffer is full.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- XLEN, 32, width of the pc, instr and result fields.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- trace_en  input  1  1 = capture retirements; 0 = discard them
- wb_valid  input  1  WB stage retires an instruction this cycle
- wb_ready  output  1  tracer can accept a retirement
- wb_pc  input  XLEN  PC of the retiring instruction
- wb_instr  input  32  instruction word
- wb_result  input  XLEN  writeback value
- wb_rd  input  5  destination register
- wb_regwrite  input  1  register write enable
- monitor_valid  output  1  head entry valid
- monitor_ready  input  1  sink accepts the head entry
- monitor_pc  output  XLEN  head PC
- monitor_instr  output  32  head instruction
- monitor_result  output  XLEN  head result
- monitor_rd  output  5  head rd
- monitor_regwrite  output  1  head regwrite
- fifo_level  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (synchronous, active-high, clk posedge):
  - count = 0, read/write pointers = 0.
  - All monitor_* outputs = 0, monitor_valid = 0, fifo_level = 0.
  - Reset asserted mid-operation discards all buffered entries in that cycle; no entry is emitted afterwards.
- Push:
  - Occurs when wb_valid && wb_ready && trace_en.
  - Stored fields are {wb_pc, wb_instr, wb_result, wb_rd, wb_regwrite && (wb_rd != 0)}.
  - x0 writes are stored with regwrite = 0; result is stored unmodified.
- wb_ready:
  - When trace_en = 1: wb_ready = !full, decoded from the registered count only. No combinational path from monitor_ready.
  - When trace_en = 0: wb_ready = 1 and the retirement is dropped. The FIFO contents still drain normally.
- Pop:
  - Occurs when monitor_valid && monitor_ready; the read pointer advances.
- monitor_* outputs:
  - Driven from the FIFO head; monitor_valid = (count != 0).
  - While monitor_valid = 1 && monitor_ready = 0, all monitor_* outputs hold stable.
  - When count = 0, monitor_* data outputs are 0.
- Latency: a push into an empty FIFO appears on monitor_* in the next cycle. There is no same-cycle bypass.
- Simultaneous push and pop:
  - Legal when 0 < count < DEPTH; count is unchanged.
  - At count = DEPTH no push occurs because wb_ready = 0, even if a pop happens that cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- count saturates logically at DEPTH (the full/empty guards make overflow impossible).
- Order is strict FIFO; entries are never reordered or duplicated.
- fifo_level = count, registered.

Optional Feature:
- Macro: COMMIT_TRACE_INSTRET_EN.
- When defined:
  - Adds output monitor_instret, 64 bits.
  - A retirement counter resets to 0 and increments on every pop.
  - monitor_instret presents the pre-increment value alongside the head entry, i.e. the 0-based sequence number of the displayed instruction. It wraps modulo 2^64.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package riscv_trace_pkg:
  - typedef commit_entry_t, a packed struct {pc, instr, result, rd, regwrite}.
  - localparam TRACE_DEPTH_DEFAULT = 4.
  - REG_X0 = 5'd0.
- Natural sub-module: riscv_trace_fifo.
  - Generic synchronous FIFO of commit_entry_t with count, full and empty outputs.
  - The top level adds x0 normalisation, trace_en gating and the optional instret counter.

Test Plan:
- Single retirement with an idle sink:
  - Stimulus: push pc=0x100, instr=0x00500093, result=5, rd=1, regwrite=1 at cycle N, monitor_ready=1.
  - Required: monitor_valid=1 with identical fields at cycle N+1, fifo_level returns to 0 at N+2.
- x0 normalisation:
  - Stimulus: push rd=0, regwrite=1, result=0x7.
  - Required: monitor_regwrite=0, monitor_result=0x7.
- Fill and back-pressure:
  - Stimulus: monitor_ready=0, push 5 consecutive entries, DEPTH=4.
  - Required: wb_ready=0 after the 4th push, fifo_level=4, 5th entry not accepted.
  - Then: assert monitor_ready; entries emerge in order pc=0x0,0x4,0x8,0xC and wb_ready returns to 1 one cycle after the first pop.
- Simultaneous push/pop:
  - Stimulus: at fifo_level=2, push and pop in the same cycle.
  - Required: fifo_level stays 2, head advances.
  - Also: pointer wrap is checked over 10 cycles of continuous traffic with no loss.
- trace_en=0 and reset mid-stream:
  - Stimulus: with trace_en=0, push 3 entries.
  - Required: wb_ready=1, fifo_level=0.
  - Stimulus: with 3 entries buffered, assert reset for 1 cycle.
  - Required: next cycle monitor_valid=0, all monitor_* outputs = 0, fifo_level=0.
- COMMIT_TRACE_INSTRET_EN:
  - Stimulus: 3 pops.
  - Required: monitor_instret shows 0, 1, 2, and is 0 after reset.
